// File: rtl/tone_note_decoder.sv
// tone_note_decoder
//   Samples an asynchronous square-wave tone, measures every half-period in
//   clk cycles, matches it against the melody note table and reports a
//   stable (debounced) note code. Silent gaps between notes are detected
//   when no edge arrives for SILENCE_CYC cycles.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   tone_in       in   square-wave tone, asynchronous to clk
//   note_code     out  locked note: 0 none, 1 D5, 2 E5, 3 F#5, 4 G5, 5 A5, 6 B5
//   note_valid    out  one-cycle pulse when note_code takes a newly locked value
//   note_active   out  high while locked
//   silence_pulse out  one-cycle pulse when a silent gap is declared
//   half_period   out  last measured half-period in cycles
module tone_note_decoder #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned TOL         = 64,
  parameter int unsigned STABLE_N    = 4,
  parameter int unsigned MISS_MAX    = 2,
  parameter int unsigned SILENCE_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tone_in,
  output logic [2:0]       note_code,
  output logic             note_valid,
  output logic             note_active,
  output logic             silence_pulse,
  output logic [CNT_W-1:0] half_period
);

  typedef enum logic [1:0] {
    ST_SILENT  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  typedef logic [CNT_W:0] diff_t;

  // Exact half-periods of the generator's notes, in note-code order 1..6.
  localparam int unsigned NOTE_HP [6] = '{8514, 7585, 6758, 6379, 5683, 5063};

  localparam logic [CNT_W-1:0] SIL_MAX  = CNT_W'(SILENCE_CYC);
  localparam logic [3:0]       RUN_LOCK = 4'(STABLE_N);
  localparam logic [2:0]       MISS_LIM = 3'(MISS_MAX);
  localparam diff_t            TOL_D    = diff_t'(TOL);

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [2:0]       cand_q, cand_d;
  logic [3:0]       run_q, run_d;
  logic [2:0]       miss_q, miss_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             sil_q, sil_d;

  logic             edge_det;
  logic [2:0]       match;
  diff_t            meas_w;
  diff_t            entry_w;
  diff_t            diff_w;

  assign edge_det = sync2_q ^ prev_q;

  // Table lookup on the running count; only meaningful when edge_det is high.
  // Entries are at least 379 apart, so with TOL=64 at most one can hit.
  always_comb begin
    match   = '0;
    meas_w  = {1'b0, cnt_q};
    entry_w = '0;
    diff_w  = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      entry_w = diff_t'(NOTE_HP[i]);
      diff_w  = (meas_w >= entry_w) ? (meas_w - entry_w) : (entry_w - meas_w);
      if (diff_w <= TOL_D) begin
        match = 3'(i + 1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SILENT;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      hp_q    <= '0;
      cand_q  <= '0;
      run_q   <= '0;
      miss_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      sil_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
      miss_q  <= miss_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      sil_q   <= sil_d;
    end
  end

  // Next-state logic
  always_comb begin
    sync1_d = tone_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    hp_d    = hp_q;
    cand_d  = cand_q;
    run_d   = run_q;
    miss_d  = miss_q;
    code_d  = code_q;
    valid_d = 1'b0;
    sil_d   = 1'b0;
    cnt_d   = (cnt_q >= SIL_MAX) ? SIL_MAX : (cnt_q + CNT_W'(1));

    // An edge takes priority over a silence timeout landing in the same cycle.
    if (edge_det) begin
      cnt_d = CNT_W'(1);
      case (state_q)
        ST_SILENT: begin
          state_d = ST_ACQUIRE;
          cand_d  = '0;
          run_d   = '0;
        end
        ST_ACQUIRE: begin
          hp_d = cnt_q;
          if (match == 3'd0) begin
            run_d = '0;
          end else if (match == cand_q) begin
            run_d = run_q + 4'd1;
          end else begin
            cand_d = match;
            run_d  = 4'd1;
          end
          if (run_d == RUN_LOCK) begin
            state_d = ST_LOCKED;
            code_d  = cand_d;
            miss_d  = '0;
            valid_d = 1'b1;
          end
        end
        ST_LOCKED: begin
          hp_d = cnt_q;
          if (match == code_q) begin
            miss_d = '0;
          end else if (match == 3'd0) begin
            miss_d = miss_q + 3'd1;
            if (miss_d == MISS_LIM) begin
              state_d = ST_ACQUIRE;
              cand_d  = '0;
              run_d   = '0;
            end
          end else begin
            cand_d = match;
            run_d  = 4'd1;
            miss_d = '0;
            // A single-measurement lock threshold would otherwise be skipped
            // over, so relock to the new note directly.
            if (STABLE_N == 1) begin
              code_d  = match;
              valid_d = 1'b1;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end
        end
        default: begin
          state_d = ST_SILENT;
        end
      endcase
    end else if ((state_q != ST_SILENT) && (cnt_q >= SIL_MAX)) begin
      state_d = ST_SILENT;
      code_d  = '0;
      sil_d   = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    note_code     = code_q;
    note_valid    = valid_q;
    note_active   = (state_q == ST_LOCKED);
    silence_pulse = sil_q;
    half_period   = hp_q;
  end

endmodule

// File: tb/tb_tone_note_decoder.sv
module tb_tone_note_decoder;

  localparam int CNT_W  = 24;
  localparam int TOL    = 64;
  localparam int STABLE = 2;
  localparam int MISS   = 2;
  localparam int SIL    = 9000;
  localparam int NOTE_HP [6] = '{8514, 7585, 6758, 6379, 5683, 5063};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tone_in = 1'b0;
  logic [2:0]       note_code;
  logic             note_valid;
  logic             note_active;
  logic             silence_pulse;
  logic [CNT_W-1:0] half_period;

  tone_note_decoder #(
    .CNT_W      (CNT_W),
    .TOL        (TOL),
    .STABLE_N   (STABLE),
    .MISS_MAX   (MISS),
    .SILENCE_CYC(SIL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tone_in      (tone_in),
    .note_code    (note_code),
    .note_valid   (note_valid),
    .note_active  (note_active),
    .silence_pulse(silence_pulse),
    .half_period  (half_period)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int since  = 0;
  int tog_cyc = 0;
  int n_valid = 0;
  int n_sil   = 0;
  int n_both  = 0;

  always @(posedge clk) cyc++;

  // Behavioural model: every tone level change is seen two cycles later,
  // and each measurement is the distance between successive seen changes.
  bit m_armed  = 1'b0;
  bit m_locked = 1'b0;
  bit m_valid  = 1'b0;
  bit m_sil    = 1'b0;
  int m_cand = 0, m_run = 0, m_miss = 0, m_code = 0, m_hp = 0;
  int m_now = 0, m_last = 0;
  int el, meas, m;
  bit seen;
  bit tq[$] = '{1'b0, 1'b0, 1'b0};

  function automatic int note_of(input int v);
    int r = 0;
    for (int i = 0; i < 6; i++) begin
      if (((v > NOTE_HP[i]) ? (v - NOTE_HP[i]) : (NOTE_HP[i] - v)) <= TOL) r = i + 1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tq = '{1'b0, 1'b0, 1'b0};
      m_armed = 1'b0; m_locked = 1'b0; m_valid = 1'b0; m_sil = 1'b0;
      m_cand = 0; m_run = 0; m_miss = 0; m_code = 0; m_hp = 0;
      m_now = 0; m_last = 0;
    end else begin
      seen = (tq[1] != tq[0]);
      tq.push_back(tone_in);
      void'(tq.pop_front());
      m_valid = 1'b0;
      m_sil   = 1'b0;
      el = m_now - m_last;
      if (seen) begin
        if (!m_armed) begin
          m_armed = 1'b1; m_locked = 1'b0; m_cand = 0; m_run = 0;
        end else begin
          meas = (el > SIL) ? SIL : el;
          m_hp = meas;
          m = note_of(meas);
          if (m_locked) begin
            if (m == m_code) m_miss = 0;
            else if (m == 0) begin
              m_miss++;
              if (m_miss >= MISS) begin m_locked = 1'b0; m_cand = 0; m_run = 0; end
            end else begin
              m_locked = 1'b0; m_cand = m; m_run = 1;
            end
          end else begin
            if (m == 0) m_run = 0;
            else if (m == m_cand) m_run++;
            else begin m_cand = m; m_run = 1; end
          end
          if (!m_locked && m_run >= STABLE) begin
            m_locked = 1'b1; m_code = m_cand; m_miss = 0; m_valid = 1'b1;
          end
        end
        m_last = m_now;
      end else if (m_armed && el >= SIL) begin
        m_armed = 1'b0; m_locked = 1'b0; m_code = 0; m_sil = 1'b1;
      end
      m_now++;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    checks++;
    if (note_code !== 3'(m_code) || note_valid !== m_valid || note_active !== m_locked ||
        silence_pulse !== m_sil || half_period !== CNT_W'(m_hp)) begin
      fails++;
      $display("FAIL cyc=%0d per_cycle got/expected: code=%0d/%0d valid=%0b/%0b active=%0b/%0b sil=%0b/%0b hp=%0d/%0d",
               cyc, note_code, m_code, note_valid, m_valid, note_active, m_locked,
               silence_pulse, m_sil, half_period, m_hp);
    end
    if (note_valid === 1'b1) n_valid++;
    if (silence_pulse === 1'b1) n_sil++;
    if (note_valid === 1'b1 && silence_pulse === 1'b1) n_both++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Toggle tone_in n cycles after the previous toggle, then let it settle.
  task automatic pulse(input int n);
    repeat (n - since) @(negedge clk);
    tone_in = ~tone_in;
    tog_cyc = cyc;
    repeat (3) @(negedge clk);
    since = 3;
  endtask

  task automatic chk_out(input string name, input int code, input int active, input int hp);
    chk({name, ".code"}, int'(note_code), code);
    chk({name, ".active"}, int'(note_active), active);
    chk({name, ".hp"}, int'(half_period), hp);
  endtask

  initial begin
    int guard;
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk_out("reset", 0, 0, 0);
    chk("reset.valid", int'(note_valid), 0);
    chk("reset.sil", int'(silence_pulse), 0);
    rst = 1'b0;

    // first edge only arms
    since = 0;
    pulse(5);
    chk_out("arm0", 0, 0, 0);

    // G5 at the upper tolerance bound locks on the second measurement
    pulse(6443);
    chk_out("tol_a1", 0, 0, 6443);
    pulse(6443);
    chk_out("tol_lock", 4, 1, 6443);

    // single glitch keeps the lock
    pulse(3000);
    chk_out("glitch1", 4, 1, 3000);
    pulse(6379);
    chk_out("glitch1_back", 4, 1, 6379);

    // asynchronous reset while locked
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0);
    chk("async_rst.valid", int'(note_valid), 0);
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    since = 0;
    pulse(5);
    chk_out("arm1", 0, 0, 0);

    // E5 lock then note change to A5
    pulse(7585);
    pulse(7585);
    chk_out("e5_lock", 2, 1, 7585);
    pulse(5683);
    chk_out("a5_first", 2, 0, 5683);
    pulse(5683);
    chk_out("a5_lock", 5, 1, 5683);

    // just outside tolerance: two misses leave LOCKED, nothing relocks
    pulse(6444);
    chk_out("miss1", 5, 1, 6444);
    pulse(6444);
    chk_out("miss2", 5, 0, 6444);

    // B5 lock, then silence
    pulse(5063);
    pulse(5063);
    chk_out("b5_lock", 6, 1, 5063);
    guard = 0;
    while (silence_pulse !== 1'b1 && guard < SIL + 50) begin
      @(negedge clk);
      guard++;
    end
    // two synchronizer cycles before the edge is seen, then SIL cycles, then the registered pulse
    chk("silence_delay", cyc - tog_cyc, SIL + 3);
    chk_out("silent", 0, 0, 5063);

    // after silence the next edge only arms
    since = 0;
    pulse(10);
    chk_out("arm2", 0, 0, 5063);
    repeat (5) @(negedge clk);

    chk("valid_pulses", n_valid, 4);
    chk("silence_pulses", n_sil, 1);
    chk("valid_sil_overlap", n_both, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
